// File: rtl/voice_scheduler.sv
// voice_scheduler: shares one single-port sample ROM among four drum voices
// (0 kick, 1 clap, 2 hihat, 3 snare). On each sample tick the voices are
// visited in order 0..3; every active voice gets one ROM byte read. The
// signed samples are summed, and the sum is saturated into one signed 8-bit
// mix word.
//
// Optional feature: define VOICE_SCHED_LOOP_EN to add the loop[3:0] input.
// With it, a voice whose loop bit is set wraps to position 0 after its last
// byte and keeps playing. Without it, every voice stops after its last byte.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for tick; pending triggers are applied when it arrives
// SLOT   | visiting voice vsel; mem_rd is high here if that voice is active
// WAIT   | ROM byte for vsel is on mem_data; accumulate it and advance pos
// FINISH | saturate acc into mix; mix_valid rises on the next cycle

module voice_scheduler #(
    parameter int POS_W      = 12,
    parameter int SAMPLE_LEN = 4000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [3:0]       trig,
    input  logic [3:0]       mute,
`ifdef VOICE_SCHED_LOOP_EN
    input  logic [3:0]       loop,
`endif
    output logic             mem_rd,
    output logic [POS_W+1:0] mem_addr,
    input  logic [7:0]       mem_data,
    output logic [7:0]       mix,
    output logic             mix_valid,
    output logic [3:0]       active,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, SLOT, WAIT, FINISH} state_t;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(SAMPLE_LEN - 1);

    state_t           state;
    logic [1:0]       vsel;
    logic [1:0]       v_next;
    logic [POS_W-1:0] pos [4];
    logic [3:0]       trig_pend;
    logic [9:0]       acc;
    logic [9:0]       acc_sum;
    logic [7:0]       clamp;
    logic             last_byte;
    logic             keep_active;

    // Next-voice index, accumulator update, saturation and end-of-sample decode
    always_comb begin
        v_next    = vsel + 2'd1;
        acc_sum   = acc + (mute[vsel] ? 10'd0 : {{2{mem_data[7]}}, mem_data});
        last_byte = (pos[vsel] == LAST_POS);
`ifdef VOICE_SCHED_LOOP_EN
        keep_active = loop[vsel];
`else
        keep_active = 1'b0;
`endif
        if ($signed(acc) > 10'sd127)
            clamp = 8'h7F;
        else if ($signed(acc) < -10'sd128)
            clamp = 8'h80;
        else
            clamp = acc[7:0];
    end

    assign busy = (state != IDLE);

    // Frame sequencer. mem_rd and mem_addr are registered and set up as the
    // FSM enters a SLOT, so the read strobe lines up with the SLOT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vsel      <= 2'd0;
            trig_pend <= 4'd0;
            acc       <= 10'd0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mix       <= 8'd0;
            mix_valid <= 1'b0;
            active    <= 4'd0;
            overrun   <= 1'b0;
            for (int i = 0; i < 4; i++) pos[i] <= '0;
        end else begin
            mix_valid <= 1'b0;
            mem_rd    <= 1'b0;
            trig_pend <= trig_pend | trig;
            if (tick && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick) begin
                        for (int i = 0; i < 4; i++) begin
                            if (trig_pend[i]) begin
                                active[i] <= 1'b1;
                                pos[i]    <= '0;
                            end
                        end
                        // A trigger arriving with the accepted tick belongs to the next frame
                        trig_pend <= trig;
                        acc       <= 10'd0;
                        vsel      <= 2'd0;
                        mem_rd    <= active[0] | trig_pend[0];
                        mem_addr  <= {2'd0, trig_pend[0] ? {POS_W{1'b0}} : pos[0]};
                        state     <= SLOT;
                    end
                end
                SLOT: begin
                    if (active[vsel]) begin
                        state <= WAIT;
                    end else if (vsel == 2'd3) begin
                        state <= FINISH;
                    end else begin
                        vsel     <= v_next;
                        mem_rd   <= active[v_next];
                        mem_addr <= {v_next, pos[v_next]};
                    end
                end
                WAIT: begin
                    acc <= acc_sum;
                    if (last_byte) begin
                        pos[vsel]    <= '0;
                        active[vsel] <= keep_active;
                    end else begin
                        pos[vsel] <= pos[vsel] + 1'b1;
                    end
                    if (vsel == 2'd3) begin
                        state <= FINISH;
                    end else begin
                        vsel     <= v_next;
                        mem_rd   <= active[v_next];
                        mem_addr <= {v_next, pos[v_next]};
                        state    <= SLOT;
                    end
                end
                FINISH: begin
                    mix       <= clamp;
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Testbench for voice_scheduler. It uses a ROM model that answers one cycle
// after each read. A frame-level reference model keeps, for each voice, the
// active flag, the play position and the pending trigger, and computes the
// expected reads, the saturated mix and the frame latency.
module tb_voice_scheduler;

    localparam int POS_W = 12;
    localparam int LEN   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  trig = 4'd0;
    logic [3:0]  mute = 4'd0;
`ifdef VOICE_SCHED_LOOP_EN
    logic [3:0]  loop = 4'd0;
`endif
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic [7:0]  mix;
    logic        mix_valid;
    logic [3:0]  active;
    logic        busy;
    logic        overrun;

    logic [7:0]  rom [16384];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit       m_act [4];
    int       m_pos [4];
    bit [3:0] m_pend;
    bit       m_ovr;

    logic [13:0] rd_q [$];
    bit          prev_rd = 1'b0;
    bit          b2b = 1'b0;

    always #5 clk = ~clk;

    voice_scheduler #(.POS_W(POS_W), .SAMPLE_LEN(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .trig     (trig),
        .mute     (mute),
`ifdef VOICE_SCHED_LOOP_EN
        .loop     (loop),
`endif
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mix      (mix),
        .mix_valid(mix_valid),
        .active   (active),
        .busy     (busy),
        .overrun  (overrun)
    );

    // ROM: data one cycle after the strobe, junk otherwise
    always @(posedge clk) mem_data <= mem_rd ? rom[mem_addr] : 8'($urandom);

    // read monitor
    always @(posedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (mem_rd && prev_rd) b2b = 1'b1;
        prev_rd = mem_rd;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_act_vec();
        logic [3:0] r;
        for (int v = 0; v < 4; v++) r[v] = m_act[v];
        return r;
    endfunction

    task automatic fill_rom(input int mode, input logic [7:0] val);
        for (int i = 0; i < 16384; i++) rom[i] = (mode == 0) ? val : 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick = 1'b0;
        trig = 4'd0;
        for (int v = 0; v < 4; v++) begin
            m_act[v] = 1'b0;
            m_pos[v] = 0;
        end
        m_pend = 4'd0;
        m_ovr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: trig pulse, then a tick one cycle later. xc > 0 adds a
    // second tick (plus trigger xt) in cycle xc. xc < 0 picks a random busy cycle.
    task automatic run_frame(input string tag, input logic [3:0] trg, input logic [3:0] mt,
                             input int xc_in, input logic [3:0] xt);
        int n, k, acc, d, idx, pulses, xc;
        logic [13:0] exp_q [$];
        logic [7:0]  exp_mix;
        @(negedge clk);
        trig = trg;
        mute = mt;
        m_pend |= trg;
        @(negedge clk);
        trig = 4'd0;
        tick = 1'b1;
        rd_q.delete();
        for (int v = 0; v < 4; v++) begin
            if (m_pend[v]) begin
                m_act[v] = 1'b1;
                m_pos[v] = 0;
            end
        end
        m_pend = 4'd0;
        n = 0;
        acc = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_act[v]) begin
                n++;
                idx = v * (1 << POS_W) + m_pos[v];
                exp_q.push_back(14'(idx));
                d = int'($signed(rom[idx]));
                if (!mt[v]) acc += d;
                if (m_pos[v] == LEN - 1) begin
                    m_pos[v] = 0;
`ifdef VOICE_SCHED_LOOP_EN
                    m_act[v] = loop[v];
`else
                    m_act[v] = 1'b0;
`endif
                end else begin
                    m_pos[v]++;
                end
            end
        end
        exp_mix = (acc > 127) ? 8'h7F : (acc < -128) ? 8'h80 : 8'(acc);
        xc = (xc_in < 0) ? $urandom_range(1, 5 + n) : xc_in;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, "/busy1"}, busy, 1);
            tick = (k == xc);
            trig = (k == xc) ? xt : 4'd0;
            if (k == xc) begin
                m_pend |= xt;
                m_ovr = 1'b1;
            end
        end while (!mix_valid && k < 40);
        tick = 1'b0;
        trig = 4'd0;
        chk({tag, "/cycle"}, k, 6 + n);
        chk({tag, "/mix"}, mix, exp_mix);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/active"}, active, m_act_vec());
        chk({tag, "/overrun"}, overrun, m_ovr);
        chk({tag, "/nreads"}, rd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
            chk({tag, "/addr"}, rd_q[i], exp_q[i]);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (mix_valid) pulses++;
        end
        chk({tag, "/extra_mv"}, pulses, 0);
    endtask

    initial begin
        fill_rom(1, 8'h00);
        do_reset();
        chk("rst/mem_rd", mem_rd, 0);
        chk("rst/mix", mix, 0);
        chk("rst/mix_valid", mix_valid, 0);
        chk("rst/active", active, 0);
        chk("rst/busy", busy, 0);
        chk("rst/overrun", overrun, 0);

        // no voices: six-cycle frame, zero mix, no reads
        run_frame("t2", 4'd0, 4'd0, 0, 4'd0);
        chk("t2/mix0", mix, 8'h00);

        // single voice 0
        rom[0] = 8'h10;
        run_frame("t3a", 4'b0001, 4'd0, 0, 4'd0);
        chk("t3/mix", mix, 8'h10);
        chk("t3/active", active, 4'b0001);
        chk("t3/addr0", rd_q.size() > 0 ? rd_q[0] : 14'h3FFF, 14'h0000);
        run_frame("t3b", 4'd0, 4'd0, 0, 4'd0);
        chk("t3/addr1", rd_q.size() > 0 ? rd_q[0] : 14'h3FFF, 14'h0001);

        // saturation with all voices
        fill_rom(0, 8'h7F);
        run_frame("t4p", 4'hF, 4'd0, 0, 4'd0);
        chk("t4/pos_sat", mix, 8'h7F);
        fill_rom(0, 8'h80);
        run_frame("t4n", 4'hF, 4'd0, 0, 4'd0);
        chk("t4/neg_sat", mix, 8'h80);
        fill_rom(0, 8'hF0);
        run_frame("t4m", 4'hF, 4'b1110, 0, 4'd0);
        chk("t4/muted", mix, 8'hF0);

        // voice 2 plays to its end
        fill_rom(1, 8'h00);
        do_reset();
`ifdef VOICE_SCHED_LOOP_EN
        loop = 4'b0100;
`endif
        for (int f = 0; f < 5; f++) begin
            run_frame("t5", (f == 0) ? 4'b0100 : 4'd0, 4'd0, 0, 4'd0);
            if (f < 4) chk("t5/addr", rd_q.size() > 0 ? rd_q[0] : 14'h3FFF, 14'(14'h2000 + f));
        end
`ifdef VOICE_SCHED_LOOP_EN
        chk("t5/loop_addr", rd_q.size() > 0 ? rd_q[0] : 14'h3FFF, 14'h2000);
        loop = 4'd0;
`else
        chk("t5/no_read", rd_q.size(), 0);
        chk("t5/active", active, 4'd0);
`endif

        // overrun: second tick in cycle 3 with trig for voice 0
        run_frame("t6", 4'hF, 4'd0, 3, 4'b0001);
        chk("t6/overrun", overrun, 1);
        run_frame("t6n", 4'd0, 4'd0, 0, 4'd0);
        chk("t6/retrig_addr", rd_q.size() > 0 ? rd_q[0] : 14'h3FFF, 14'h0000);

        // randomized frames
        do_reset();
        for (int f = 0; f < 40; f++) begin
            run_frame("rnd", 4'($urandom & $urandom), 4'($urandom),
                      ($urandom_range(0, 3) == 0) ? -1 : 0, 4'($urandom));
        end

        // reset in the middle of a frame with all voices active
        @(negedge clk);
        trig = 4'hF;
        @(negedge clk);
        trig = 4'd0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t1/mem_rd", mem_rd, 0);
        chk("t1/busy", busy, 0);
        chk("t1/active", active, 0);
        chk("t1/mix", mix, 0);
        chk("t1/overrun", overrun, 0);
        do_reset();
        run_frame("t1post", 4'b1000, 4'd0, 0, 4'd0);

        chk("no_b2b_rd", b2b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
